// File: rtl/demux_1a2_fifo_pkg.sv
// Shared constants for the alternating 1-to-2 demultiplexer and its lane FIFOs.
package demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // Lane indices, also the encoding of the internal selector bit.
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Lane that follows the given one in strict alternation.
  function automatic logic next_lane(input logic lane);
    return (lane == LANE0) ? LANE1 : LANE0;
  endfunction

endpackage

// File: rtl/demux_1a2_fifo_if.sv
// Handshake and lane-output bundle between the upstream stage, the demux and the lane consumers.
interface demux_1a2_fifo_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_in;
  logic [DATA_W-1:0] data_out0;
  logic              valid_out0;
  logic              pop0;
  logic [DATA_W-1:0] data_out1;
  logic              valid_out1;
  logic              pop1;
  logic              full0;
  logic              full1;

  // Upstream producer and lane consumers.
  modport master (
    output data_in, valid_in, pop0, pop1,
    input  ready_in, data_out0, valid_out0, data_out1, valid_out1, full0, full1
  );

  // The demux itself.
  modport slave (
    input  data_in, valid_in, pop0, pop1,
    output ready_in, data_out0, valid_out0, data_out1, valid_out1, full0, full1
  );

endinterface

// File: rtl/demux_1a2_fifo_fifo_sync.sv
// First-word-fall-through synchronous FIFO whose output reads as zero while empty.
module fifo_sync
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          data_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO or a pop from an empty one is dropped, so the count never leaves 0..DEPTH.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; pointers wrap because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO and ignores that cycle's push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; left unreset because empty entries are never visible on data_out.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/demux_1a2_fifo.sv
// Alternating 1-to-2 demux: each accepted word goes to the lane after the previous one.
module demux_1a2_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  demux_1a2_fifo_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             sel_q, sel_d;
  logic             accept;
  logic             push0, push1;
  logic             empty0, empty1;
  logic             lane_full0, lane_full1;
  logic [CNT_W-1:0] count0, count1;
  logic             count_unused;

  // A full target lane stalls the input even if that lane is popped this cycle, so ready depends on registered state only.
  assign bus.ready_in = ~(sel_q == LANE0 ? lane_full0 : lane_full1) & ~reset;
  assign accept       = bus.valid_in & bus.ready_in;
  assign push0        = accept & (sel_q == LANE0);
  assign push1        = accept & (sel_q == LANE1);

  assign bus.valid_out0 = ~empty0;
  assign bus.valid_out1 = ~empty1;
  assign bus.full0      = lane_full0;
  assign bus.full1      = lane_full1;

  // Occupancy counts are not needed for the handshake.
  assign count_unused = ^{count0, count1};

  // The selector advances only on an accepted word, so a stalled word keeps its lane.
  always_comb begin
    sel_d = sel_q;
    if (accept) begin
      sel_d = next_lane(sel_q);
    end
  end

  // Selector register; reset restarts alternation at lane 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= LANE0;
    end else begin
      sel_q <= sel_d;
    end
  end

  fifo_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_lane0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (bus.data_in),
    .pop       (bus.pop0),
    .data_out  (bus.data_out0),
    .empty     (empty0),
    .full      (lane_full0),
    .count     (count0)
  );

  fifo_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (bus.data_in),
    .pop       (bus.pop1),
    .data_out  (bus.data_out1),
    .empty     (empty1),
    .full      (lane_full1),
    .count     (count1)
  );

endmodule

// File: doc/demux_1a2_fifo.md
Name: demux_1a2_fifo

Overview:
- 1-to-2 demultiplexer with an automatic alternating selector, valid/ready handshake on the input, and a small synchronous FIFO per output lane.
- Sits directly upstream of the demux equivalence checker. Its data_out0/data_out1 drive the checker's lane inputs, one instance per implementation (behavioural and structural).
- Outputs are forced to zero when a lane is empty, so two equivalent instances compare bit-exact every cycle.

Parameters:
- DATA_W, 8, width of the data word.
- DEPTH, 4, entries per lane FIFO. Power of two, minimum 2.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- data_in, input, DATA_W, word offered by the upstream stage.
- valid_in, input, 1, data_in is valid this cycle.
- ready_in, output, 1, block accepts data_in this cycle (combinational).
- data_out0, output, DATA_W, head of lane 0 FIFO; 0 when lane 0 is empty.
- valid_out0, output, 1, lane 0 non-empty.
- pop0, input, 1, consumer removes the lane 0 head.
- data_out1, output, DATA_W, head of lane 1 FIFO; 0 when lane 1 is empty.
- valid_out1, output, 1, lane 1 non-empty.
- pop1, input, 1, consumer removes the lane 1 head.
- full0, output, 1, lane 0 holds DEPTH entries.
- full1, output, 1, lane 1 holds DEPTH entries.

Behaviour:
- **Reset** (reset=1 at a rising edge):
  - sel=0.
  - All read/write pointers and counts = 0.
  - valid_out0/1=0, data_out0/1=0, full0/1=0.
  - FIFO storage contents don't care; they are never visible because empty lanes output 0.
  - Reset mid-operation flushes both lanes immediately, discarding stored words.
  - Input and pop activity in a reset cycle is ignored.
- **Selector:**
  - Internal 1-bit sel, starting at 0.
  - Toggles only on an accepted input word (valid_in & ready_in).
  - Strict alternation: lane 0, lane 1, lane 0, …
  - A blocked word does not skip to the other lane.
- **Input handshake:**
  - ready_in = !full[sel] & !reset.
  - On accept, data_in is written at wr_ptr[sel], which increments modulo DEPTH.
  - valid_in=0 means no write and sel holds, whatever ready_in is.
- **Output:**
  - First-word fall-through: data_outN = mem_N[rd_ptr_N] when countN>0, else 0.
  - valid_outN = (countN != 0).
  - Latency: a word accepted at edge k appears on data_outN/valid_outN immediately after edge k, provided the lane was empty.
- **Pop:**
  - popN & valid_outN at an edge removes the head: rd_ptr_N increments modulo DEPTH, countN decrements.
  - popN while the lane is empty is ignored; count does not underflow.
- **Simultaneous events:**
  - Push and pop on the same non-full lane in one cycle: count is unchanged, both pointers advance.
  - Push to lane 0 and pop of lane 1 in one cycle are independent.
  - Lane full: ready_in=0 even if popN is asserted that cycle. There is no full-bypass, which keeps the handshake purely registered-state based.
- **Widths and wrap:**
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Counts are log2(DEPTH)+1 bits, range 0..DEPTH.
  - fullN = (countN == DEPTH).

Decomposition:
- Shared package demux_pkg holds:
  - DATA_W_DEF=8 and DEPTH_DEF=4;
  - the lane index constants LANE0=0 and LANE1=1.
- One natural sub-module: fifo_sync, a parameterised FWFT FIFO with zero-on-empty output, push, pop, full, empty and count.
- fifo_sync is instantiated twice.
- The top level holds only the selector and the handshake logic.

Test Plan:
1. **Reset:** hold reset 2 cycles with valid_in=1 and data_in=8'hAA. Required: ready_in=0, valid_out0/1=0, data_out0/1=8'h00, nothing stored after release.
2. **Alternation:** stream 8'h01,02,03,04 with no pops. Required: lane0 holds 01,03 and lane1 holds 02,04; data_out0=01 and data_out1=02 one edge after their accept.
3. **Full and backpressure (DEPTH=4):**
   - Push 8 words 10..17 with no pops. Required: full0=full1=1.
   - Then offer 18. Required: ready_in=0 and sel stays 0.
   - Then pop0 once. Required: data_out0=12, and 18 is accepted the next cycle into lane 0.
4. **Empty pop:** pop0=pop1=1 while both lanes are empty. Required: counts stay 0, data_out=0, no pointer movement.
5. **Simultaneous push/pop:** lane0 holds {20}; push 8'h21 to lane 0 and pop0 in the same cycle. Required: data_out0=21 next cycle, count0=1.
6. **Reset mid-stream:** with 3 words stored, assert reset 1 cycle. Required: all lanes empty, outputs 0, and the next accepted word goes to lane 0.
